// File: rtl/csr_cmd_pkg.sv
// csr_cmd_pkg: shared encodings for the CSR command sequencer.
//   op_e        - request opcodes driven by the WB stage (5..7 reserved)
//   state_e     - sequencer states
//   ECODE_INT   - exception code used when an interrupt replaces a request
//   FULL_WMASK  - write mask for a whole-register CSRWR
package csr_cmd_pkg;

    typedef enum logic [2:0] {
        OP_CSRRD   = 3'd0,
        OP_CSRWR   = 3'd1,
        OP_CSRXCHG = 3'd2,
        OP_ERTN    = 3'd3,
        OP_EXC     = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP,
        ST_TRAP,
        ST_REDIR
    } state_e;

    localparam logic [5:0]  ECODE_INT  = 6'h00;
    localparam logic [31:0] FULL_WMASK = 32'hFFFF_FFFF;

    // True for the ops that read (and possibly write) a CSR and return a GPR value.
    function automatic logic is_csr_op(input logic [2:0] op);
        return (op == OP_CSRRD) || (op == OP_CSRWR) || (op == OP_CSRXCHG);
    endfunction

endpackage

// File: rtl/csr_cmd_unit.sv
// csr_cmd_unit: pipeline-side initiator for the CSR register file.
// Accepts one CSR-class instruction at a time, performs read-before-write
// for csrrd/csrwr/csrxchg and returns the old value, or raises wb_ex /
// ertn_flush followed by a one-cycle fetch redirect.
// Ports:
//   clk, resetn                  - clock, async active-low reset
//   req_*                        - request from WB (valid/ready)
//   resp_*                       - old CSR value back to GPR write-back
//   csr_re/num/rvalue/we/wmask/wvalue - CSR file access port
//   wb_ex, ertn_flush, wb_*      - trap strobes and exception info
//   ex_entry, ertn_pc, has_int   - trap targets and pending interrupt
//   redirect_valid/pc            - one-cycle fetch redirect
module csr_cmd_unit
    import csr_cmd_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int CSR_NUM_W = 14
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_op,
    input  logic [CSR_NUM_W-1:0] req_csr_num,
    input  logic [XLEN-1:0]      req_rd_val,
    input  logic [XLEN-1:0]      req_rj_val,
    input  logic [XLEN-1:0]      req_pc,
    input  logic [XLEN-1:0]      req_vaddr,
    input  logic [5:0]           req_ecode,
    input  logic [8:0]           req_esubcode,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [XLEN-1:0]      resp_rdata,
    output logic                 resp_rd_we,
    output logic                 csr_re,
    output logic [CSR_NUM_W-1:0] csr_num,
    input  logic [XLEN-1:0]      csr_rvalue,
    output logic                 csr_we,
    output logic [XLEN-1:0]      csr_wmask,
    output logic [XLEN-1:0]      csr_wvalue,
    output logic                 wb_ex,
    output logic                 ertn_flush,
    output logic [5:0]           wb_ecode,
    output logic [8:0]           wb_esubcode,
    output logic [XLEN-1:0]      wb_pc,
    output logic [XLEN-1:0]      wb_vaddr,
    input  logic [XLEN-1:0]      ex_entry,
    input  logic [XLEN-1:0]      ertn_pc,
    input  logic                 has_int,
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_pc
);

    state_e                 state_q, state_d;
    logic [2:0]             op_q;
    logic [CSR_NUM_W-1:0]   num_q;
    logic [XLEN-1:0]        rd_val_q, rj_val_q, pc_q, vaddr_q, rdata_q, redir_pc_q;
    logic [5:0]             ecode_q;
    logic [8:0]             esubcode_q;
    logic                   rd_we_q;
    logic                   accept;

    assign accept = req_valid && (state_q == ST_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (has_int)                 state_d = ST_TRAP;
                    else if (is_csr_op(req_op))  state_d = ST_READ;
                    else if (req_op == OP_ERTN || req_op == OP_EXC) state_d = ST_TRAP;
                    else                         state_d = ST_RESP;
                end
            end
            ST_READ:  state_d = (op_q == OP_CSRRD) ? ST_RESP : ST_WRITE;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  if (resp_ready) state_d = ST_IDLE;
            ST_TRAP:  state_d = ST_REDIR;
            ST_REDIR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Request capture. An interrupt pending at accept replaces the request
    // with an EXC carrying the interrupt code; the original op is dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q       <= '0;
            num_q      <= '0;
            rd_val_q   <= '0;
            rj_val_q   <= '0;
            pc_q       <= '0;
            vaddr_q    <= '0;
            ecode_q    <= '0;
            esubcode_q <= '0;
            rd_we_q    <= 1'b0;
            rdata_q    <= '0;
            redir_pc_q <= '0;
        end else begin
            if (accept) begin
                num_q    <= req_csr_num;
                rd_val_q <= req_rd_val;
                rj_val_q <= req_rj_val;
                pc_q     <= req_pc;
                rdata_q  <= '0;
                if (has_int) begin
                    op_q       <= OP_EXC;
                    ecode_q    <= ECODE_INT;
                    esubcode_q <= '0;
                    vaddr_q    <= '0;
                    rd_we_q    <= 1'b0;
                end else begin
                    op_q       <= req_op;
                    ecode_q    <= req_ecode;
                    esubcode_q <= req_esubcode;
                    vaddr_q    <= req_vaddr;
                    rd_we_q    <= is_csr_op(req_op);
                end
            end
            if (state_q == ST_READ) rdata_q <= csr_rvalue;
            // Target is sampled during the strobe cycle, then held for REDIR.
            if (state_q == ST_TRAP) redir_pc_q <= (op_q == OP_EXC) ? ex_entry : ertn_pc;
        end
    end

    // Outputs are pure decodes of state; IDLE drives everything low, so an
    // async reset drops any in-flight strobe at once.
    always_comb begin
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_rdata     = '0;
        resp_rd_we     = 1'b0;
        csr_re         = 1'b0;
        csr_we         = 1'b0;
        csr_num        = '0;
        csr_wmask      = '0;
        csr_wvalue     = '0;
        wb_ex          = 1'b0;
        ertn_flush     = 1'b0;
        wb_ecode       = '0;
        wb_esubcode    = '0;
        wb_pc          = '0;
        wb_vaddr       = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        unique case (state_q)
            ST_IDLE:  req_ready = resetn;
            ST_READ: begin
                csr_re  = 1'b1;
                csr_num = num_q;
            end
            ST_WRITE: begin
                csr_we     = 1'b1;
                csr_num    = num_q;
                csr_wvalue = rd_val_q;
                csr_wmask  = (op_q == OP_CSRWR) ? XLEN'(FULL_WMASK) : rj_val_q;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_rd_we = rd_we_q;
            end
            ST_TRAP: begin
                if (op_q == OP_EXC) begin
                    wb_ex       = 1'b1;
                    wb_ecode    = ecode_q;
                    wb_esubcode = esubcode_q;
                    wb_pc       = pc_q;
                    wb_vaddr    = vaddr_q;
                end else begin
                    ertn_flush = 1'b1;
                end
            end
            ST_REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = redir_pc_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_cmd_unit.sv
// tb_csr_cmd_unit: directed bench for csr_cmd_unit. A one-register CSR
// model at index 0x30 (SAVE0) answers reads and applies masked writes.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_csr_cmd_unit;

    localparam logic [2:0] OP_RD = 3'd0, OP_WR = 3'd1, OP_XCHG = 3'd2,
                           OP_ERTN = 3'd3, OP_EXC = 3'd4, OP_RSV = 3'd5;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [13:0] req_csr_num;
    logic [31:0] req_rd_val, req_rj_val, req_pc, req_vaddr;
    logic [5:0]  req_ecode;
    logic [8:0]  req_esubcode;
    logic        resp_valid, resp_ready, resp_rd_we;
    logic [31:0] resp_rdata;
    logic        csr_re, csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue, csr_wmask, csr_wvalue;
    logic        wb_ex, ertn_flush;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc, wb_vaddr, ex_entry, ertn_pc;
    logic        has_int;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int errors = 0;
    int checks = 0;

    logic [31:0] save0 = 32'h1234_5678;

    always #5 clk = ~clk;

    assign csr_rvalue = (csr_num == 14'h30) ? save0 : 32'h0;
    always @(posedge clk) begin
        if (csr_we && csr_num == 14'h30)
            save0 <= (save0 & ~csr_wmask) | (csr_wvalue & csr_wmask);
    end

    csr_cmd_unit dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_csr_num(req_csr_num), .req_rd_val(req_rd_val), .req_rj_val(req_rj_val),
        .req_pc(req_pc), .req_vaddr(req_vaddr), .req_ecode(req_ecode),
        .req_esubcode(req_esubcode),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_rd_we(resp_rd_we),
        .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
        .ex_entry(ex_entry), .ertn_pc(ertn_pc), .has_int(has_int),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    // Strobes that must never coincide, checked every cycle out of reset.
    always @(negedge clk) begin
        if (resetn) begin
            checks++;
            if ((csr_re && csr_we) || (wb_ex && ertn_flush)) begin
                errors++;
                $display("FAIL excl: re=%b we=%b ex=%b ertn=%b, required no overlap",
                         csr_re, csr_we, wb_ex, ertn_flush);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one request on the falling edge; it is accepted at the next
    // rising edge (edge 0). Returns just after edge 0.
    task automatic issue(input logic [2:0] op, input logic [13:0] num,
                         input logic [31:0] rd, input logic [31:0] rj,
                         input logic [31:0] pc, input logic [31:0] va,
                         input logic [5:0] ec, input logic [8:0] esc,
                         input logic intr);
        @(negedge clk);
        req_op = op; req_csr_num = num; req_rd_val = rd; req_rj_val = rj;
        req_pc = pc; req_vaddr = va; req_ecode = ec; req_esubcode = esc;
        has_int = intr; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        has_int = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; req_valid = 1'b1; resp_ready = 1'b1; has_int = 1'b0;
        req_op = OP_RD; req_csr_num = 14'h30; req_rd_val = '0; req_rj_val = '0;
        req_pc = '0; req_vaddr = '0; req_ecode = '0; req_esubcode = '0;
        ex_entry = 32'h1C00_8000; ertn_pc = 32'h1C00_0204;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", req_ready); end
        checks++;
        if ({resp_valid, csr_re, csr_we, wb_ex, ertn_flush, redirect_valid} !== 6'b0) begin
            errors++;
            $display("FAIL rst_strobes: got %b want 000000",
                     {resp_valid, csr_re, csr_we, wb_ex, ertn_flush, redirect_valid});
        end
        req_valid = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_csrrd();
        issue(OP_RD, 14'h30, 32'h0, 32'h0, 32'h1C00_0000, 32'h0, 6'h0, 9'h0, 1'b0);
        has_int = 1'b1;  // must be ignored mid-sequence
        @(negedge clk);  // cycle 1
        checks++;
        if (csr_re !== 1'b1 || csr_num !== 14'h30 || csr_we !== 1'b0) begin
            errors++; $display("FAIL rd_c1: re=%b num=%h we=%b want 1 0030 0", csr_re, csr_num, csr_we);
        end
        @(negedge clk);  // cycle 2
        has_int = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h1234_5678 || resp_rd_we !== 1'b1) begin
            errors++; $display("FAIL rd_resp: v=%b d=%h we=%b want 1 12345678 1", resp_valid, resp_rdata, resp_rd_we);
        end
        checks++;
        if (csr_re !== 1'b0 || csr_we !== 1'b0 || wb_ex !== 1'b0) begin
            errors++; $display("FAIL rd_c2_strobes: re=%b we=%b ex=%b want 0 0 0", csr_re, csr_we, wb_ex);
        end
        @(negedge clk);  // cycle 3
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rd_done: v=%b ready=%b want 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_csrxchg_stall();
        resp_ready = 1'b0;
        issue(OP_XCHG, 14'h30, 32'hFFFF_0000, 32'h00FF_00FF, 32'h0, 32'h0, 6'h0, 9'h0, 1'b0);
        @(negedge clk);  // cycle 1
        checks++;
        if (csr_re !== 1'b1 || csr_we !== 1'b0) begin
            errors++; $display("FAIL xchg_c1: re=%b we=%b want 1 0", csr_re, csr_we);
        end
        @(negedge clk);  // cycle 2
        checks++;
        if (csr_we !== 1'b1 || csr_wmask !== 32'h00FF_00FF || csr_wvalue !== 32'hFFFF_0000 || csr_num !== 14'h30) begin
            errors++; $display("FAIL xchg_write: we=%b mask=%h val=%h num=%h want 1 00ff00ff ffff0000 0030",
                               csr_we, csr_wmask, csr_wvalue, csr_num);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);  // cycles 3..7, stalled
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h1234_5678 || req_ready !== 1'b0) begin
                errors++; $display("FAIL xchg_stall%0d: v=%b d=%h ready=%b want 1 12345678 0",
                                   i, resp_valid, resp_rdata, req_ready);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || save0 !== 32'h12FF_5600) begin
            errors++; $display("FAIL xchg_done: v=%b save0=%h want 0 12ff5600", resp_valid, save0);
        end
    endtask

    task automatic test_csrwr();
        issue(OP_WR, 14'h30, 32'hA5A5_A5A5, 32'h00FF_00FF, 32'h0, 32'h0, 6'h0, 9'h0, 1'b0);
        repeat (2) @(negedge clk);  // cycle 2
        checks++;
        if (csr_we !== 1'b1 || csr_wmask !== 32'hFFFF_FFFF || csr_wvalue !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL wr_write: we=%b mask=%h val=%h want 1 ffffffff a5a5a5a5", csr_we, csr_wmask, csr_wvalue);
        end
        @(negedge clk);  // cycle 3
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h12FF_5600 || save0 !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL wr_resp: v=%b d=%h save0=%h want 1 12ff5600 a5a5a5a5", resp_valid, resp_rdata, save0);
        end
        @(negedge clk);
    endtask

    task automatic test_exc();
        issue(OP_EXC, 14'h30, 32'h0, 32'h0, 32'h1C00_0100, 32'h0000_BAD0, 6'h0B, 9'h001, 1'b0);
        @(negedge clk);  // cycle 1
        checks++;
        if (wb_ex !== 1'b1 || wb_ecode !== 6'h0B || wb_esubcode !== 9'h001 || wb_pc !== 32'h1C00_0100 || wb_vaddr !== 32'h0000_BAD0) begin
            errors++; $display("FAIL exc_c1: ex=%b ec=%h esc=%h pc=%h va=%h want 1 0b 001 1c000100 0000bad0",
                               wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr);
        end
        checks++;
        if (ertn_flush !== 1'b0 || csr_re !== 1'b0 || redirect_valid !== 1'b0) begin
            errors++; $display("FAIL exc_c1_other: ertn=%b re=%b redir=%b want 0 0 0", ertn_flush, csr_re, redirect_valid);
        end
        @(negedge clk);  // cycle 2
        checks++;
        if (wb_ex !== 1'b0 || redirect_valid !== 1'b1 || redirect_pc !== 32'h1C00_8000 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL exc_redir: ex=%b rv=%b rpc=%h resp=%b want 0 1 1c008000 0",
                               wb_ex, redirect_valid, redirect_pc, resp_valid);
        end
        @(negedge clk);  // cycle 3
        checks++;
        if (redirect_valid !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL exc_done: rv=%b ready=%b resp=%b want 0 1 0", redirect_valid, req_ready, resp_valid);
        end
    endtask

    task automatic test_int();
        issue(OP_WR, 14'h30, 32'h5555_5555, 32'h0, 32'h1C00_0200, 32'h1234, 6'h3F, 9'h155, 1'b1);
        @(negedge clk);  // cycle 1
        checks++;
        if (csr_re !== 1'b0 || csr_we !== 1'b0 || wb_ex !== 1'b1) begin
            errors++; $display("FAIL int_c1: re=%b we=%b ex=%b want 0 0 1", csr_re, csr_we, wb_ex);
        end
        checks++;
        if (wb_ecode !== 6'h00 || wb_esubcode !== 9'h000 || wb_pc !== 32'h1C00_0200) begin
            errors++; $display("FAIL int_info: ec=%h esc=%h pc=%h want 00 000 1c000200", wb_ecode, wb_esubcode, wb_pc);
        end
        @(negedge clk);  // cycle 2
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1C00_8000 || csr_we !== 1'b0) begin
            errors++; $display("FAIL int_redir: rv=%b rpc=%h we=%b want 1 1c008000 0", redirect_valid, redirect_pc, csr_we);
        end
        @(negedge clk);
        checks++;
        if (save0 !== 32'hA5A5_A5A5 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL int_nowrite: save0=%h resp=%b want a5a5a5a5 0", save0, resp_valid);
        end
    endtask

    task automatic test_ertn();
        issue(OP_ERTN, 14'h0, 32'h0, 32'h0, 32'h1C00_0300, 32'h0, 6'h0, 9'h0, 1'b0);
        @(negedge clk);  // cycle 1
        checks++;
        if (ertn_flush !== 1'b1 || wb_ex !== 1'b0 || wb_pc !== 32'h0) begin
            errors++; $display("FAIL ertn_c1: flush=%b ex=%b pc=%h want 1 0 00000000", ertn_flush, wb_ex, wb_pc);
        end
        @(negedge clk);  // cycle 2
        checks++;
        if (ertn_flush !== 1'b0 || redirect_valid !== 1'b1 || redirect_pc !== 32'h1C00_0204 || req_ready !== 1'b0) begin
            errors++; $display("FAIL ertn_redir: flush=%b rv=%b rpc=%h ready=%b want 0 1 1c000204 0",
                               ertn_flush, redirect_valid, redirect_pc, req_ready);
        end
        @(negedge clk);  // cycle 3
        checks++;
        if (req_ready !== 1'b1 || redirect_valid !== 1'b0) begin
            errors++; $display("FAIL ertn_done: ready=%b rv=%b want 1 0", req_ready, redirect_valid);
        end
    endtask

    task automatic test_reserved();
        issue(OP_RSV, 14'h30, 32'h0, 32'h0, 32'h0, 32'h0, 6'h0, 9'h0, 1'b0);
        @(negedge clk);  // cycle 1
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_rd_we !== 1'b0 || csr_re !== 1'b0) begin
            errors++; $display("FAIL rsv_resp: v=%b d=%h we=%b re=%b want 1 00000000 0 0",
                               resp_valid, resp_rdata, resp_rd_we, csr_re);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        issue(OP_WR, 14'h30, 32'h0BAD_F00D, 32'h0, 32'h0, 32'h0, 6'h0, 9'h0, 1'b0);
        repeat (2) @(negedge clk);  // cycle 2, WRITE
        checks++;
        if (csr_we !== 1'b1) begin errors++; $display("FAIL mid_we: got %b want 1", csr_we); end
        resetn = 1'b0;
        #1;
        checks++;
        if ({csr_we, csr_re, req_ready, resp_valid, wb_ex, ertn_flush, redirect_valid} !== 7'b0 || csr_wvalue !== 32'h0) begin
            errors++; $display("FAIL mid_reset: strobes=%b wval=%h want 0000000 00000000",
                               {csr_we, csr_re, req_ready, resp_valid, wb_ex, ertn_flush, redirect_valid}, csr_wvalue);
        end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || save0 !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL mid_release: ready=%b save0=%h want 1 a5a5a5a5", req_ready, save0);
        end
        issue(OP_RD, 14'h30, 32'h0, 32'h0, 32'h0, 32'h0, 6'h0, 9'h0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'hA5A5_A5A5 || resp_rd_we !== 1'b1) begin
            errors++; $display("FAIL mid_after_rd: v=%b d=%h we=%b want 1 a5a5a5a5 1", resp_valid, resp_rdata, resp_rd_we);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_csrrd();
        test_csrxchg_stall();
        test_csrwr();
        test_exc();
        test_int();
        test_ertn();
        test_reserved();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
